// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - command sequencer driving the 8-deep x 4-bit calculator stack
module stack_sequencer #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic       cmd_ready,
    input  logic [3:0] top_word,
    input  logic [3:0] second_word,
    output logic       stk_mode,
    output logic       stk_move,
    output logic [3:0] stk_in_word,
    output logic [3:0] depth,
    output logic       carry,
    output logic       err,
    output logic       err_ovf,
    output logic       err_unf
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_DUP  = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_PUSH1, S_POP1,
        S_ALU_POP1, S_ALU_POP2, S_ALU_PUSH,
        S_SWP_POP1, S_SWP_POP2, S_SWP_PUSHA, S_SWP_PUSHB,
        S_CLR_LOOP, S_ERR
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] a_q, b_q, d_q;
    logic [2:0] op_q;
    logic [3:0] depth_q;
    logic       carry_q, carry_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic       accept;
    logic [4:0] alu_sum, alu_dif;
    logic [3:0] alu_r;
    logic       alu_c;

    assign accept  = cmd_valid && (state_q == S_IDLE);
    assign depth   = depth_q;
    assign carry   = carry_q;
    assign err_ovf = ovf_q;
    assign err_unf = unf_q;

    // ALU on the latched operands; bit 4 is carry-out for ADD and borrow (B<A) for SUB
    always_comb begin
        alu_sum = {1'b0, b_q} + {1'b0, a_q};
        alu_dif = {1'b0, b_q} - {1'b0, a_q};
        alu_r   = (op_q == OP_SUB) ? alu_dif[3:0] : alu_sum[3:0];
        alu_c   = (op_q == OP_SUB) ? alu_dif[4]   : alu_sum[4];
    end

    // next-state, sticky-flag updates and Moore stack controls
    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        cmd_ready   = 1'b0;
        stk_move    = 1'b0;
        stk_mode    = 1'b0;
        stk_in_word = 4'd0;
        err         = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_NOP: state_d = S_IDLE;
                        OP_PUSH: begin
                            if (depth_q < DEPTH_L) state_d = S_PUSH1;
                            else begin state_d = S_ERR; ovf_d = 1'b1; end
                        end
                        OP_DUP: begin
                            if (depth_q == 4'd0) begin state_d = S_ERR; unf_d = 1'b1; end
                            else if (depth_q >= DEPTH_L) begin state_d = S_ERR; ovf_d = 1'b1; end
                            else state_d = S_PUSH1;
                        end
                        OP_POP: begin
                            if (depth_q >= 4'd1) state_d = S_POP1;
                            else begin state_d = S_ERR; unf_d = 1'b1; end
                        end
                        OP_ADD, OP_SUB: begin
                            if (depth_q >= 4'd2) state_d = S_ALU_POP1;
                            else begin state_d = S_ERR; unf_d = 1'b1; end
                        end
                        OP_SWAP: begin
                            if (depth_q >= 4'd2) state_d = S_SWP_POP1;
                            else begin state_d = S_ERR; unf_d = 1'b1; end
                        end
                        OP_CLR: begin
                            ovf_d   = 1'b0;
                            unf_d   = 1'b0;
                            state_d = (depth_q == 4'd0) ? S_IDLE : S_CLR_LOOP;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_PUSH1: begin
                stk_move    = 1'b1;
                stk_mode    = 1'b1;
                stk_in_word = (op_q == OP_DUP) ? a_q : d_q;
                state_d     = S_IDLE;
            end
            S_POP1: begin
                stk_move = 1'b1;
                state_d  = S_IDLE;
            end
            S_ALU_POP1: begin
                stk_move = 1'b1;
                state_d  = S_ALU_POP2;
            end
            S_ALU_POP2: begin
                stk_move = 1'b1;
                state_d  = S_ALU_PUSH;
            end
            S_ALU_PUSH: begin
                stk_move    = 1'b1;
                stk_mode    = 1'b1;
                stk_in_word = alu_r;
                carry_d     = alu_c;
                state_d     = S_IDLE;
            end
            S_SWP_POP1: begin
                stk_move = 1'b1;
                state_d  = S_SWP_POP2;
            end
            S_SWP_POP2: begin
                stk_move = 1'b1;
                state_d  = S_SWP_PUSHA;
            end
            S_SWP_PUSHA: begin
                stk_move    = 1'b1;
                stk_mode    = 1'b1;
                stk_in_word = a_q;
                state_d     = S_SWP_PUSHB;
            end
            S_SWP_PUSHB: begin
                stk_move    = 1'b1;
                stk_mode    = 1'b1;
                stk_in_word = b_q;
                state_d     = S_IDLE;
            end
            S_CLR_LOOP: begin
                stk_move = 1'b1;
                if (depth_q <= 4'd1) state_d = S_IDLE;
            end
            S_ERR: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state, operand latches, depth counter and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            d_q     <= 4'd0;
            op_q    <= OP_NOP;
            depth_q <= 4'd0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (accept) begin
                a_q  <= top_word;
                b_q  <= second_word;
                d_q  <= cmd_data;
                op_q <= cmd_op;
            end
            if (stk_move) depth_q <= stk_mode ? depth_q + 4'd1 : depth_q - 4'd1;
        end
    end

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Command sequencer for the 8-deep × 4-bit calculator stack. Accepts one opcode at a time over a valid/ready handshake and drives the stack's push/pop/move controls through one or more cycles. Tracks stack depth, performs 4-bit ADD/SUB, and reports overflow/underflow and carry. Sits between the calculator's input decoder and the stack; it is the only block that drives the stack's control inputs.

## Interface
- DEPTH, 8: stack capacity in words; must match the stack instance.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset; shared with the stack.
- cmd_valid  input  1  command present.
- cmd_op  input  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 DUP, 6 SWAP, 7 CLR.
- cmd_data  input  4  literal for PUSH; ignored otherwise.
- cmd_ready  output  1  high only in IDLE.
- top_word  input  4  stack entry 0.
- second_word  input  4  stack entry 1.
- stk_mode  output  1  1 push, 0 pop.
- stk_move  output  1  stack shifts at the next edge when high.
- stk_in_word  output  4  word pushed when stk_mode=1.
- depth  output  4  valid entries, 0..DEPTH.
- carry  output  1  carry/borrow of the last ADD/SUB.
- err  output  1  one-cycle pulse on a rejected command.
- err_ovf, err_unf  output  1 each  sticky overflow/underflow flags.

## Operation
- Handshake: a command is accepted at an edge where cmd_valid && cmd_ready.
- At acceptance, latch A=top_word, B=second_word, D=cmd_data, op.
- Outputs decode from state (Moore).
- stk_move=1 in every state except IDLE and ERR.
- stk_in_word=0 whenever stk_mode=0.
- States and the steps each command runs:
  - NOP: stays in IDLE; no busy cycle.
  - PUSH (needs depth<DEPTH): PUSH1 pushes D.
  - DUP (needs 1≤depth<DEPTH): PUSH1 pushes A.
  - POP (needs depth≥1): POP1.
  - ADD/SUB (need depth≥2): ALU_POP1 → ALU_POP2 → ALU_PUSH.
    - ALU_PUSH pushes R: B+A mod 16 for ADD, B−A mod 16 for SUB.
    - carry updates at the ALU_PUSH edge: ADD carry-out of bit 3; SUB borrow (B<A).
  - SWAP (needs depth≥2): SWP_POP1 → SWP_POP2 → SWP_PUSHA (push A) → SWP_PUSHB (push B). Result: top=B, second=A.
  - CLR: clears err_ovf and err_unf at acceptance.
    - depth=0: behaves as NOP.
    - Otherwise: CLR_LOOP pops once per cycle and exits to IDLE at the edge where depth goes 1→0.
- Precondition fails: go to ERR for one cycle with err=1 and no stack movement, then return to IDLE. depth and carry are unchanged.
  - PUSH/DUP at depth=DEPTH sets err_ovf.
  - POP/DUP/ADD/SUB/SWAP with insufficient depth sets err_unf.
- depth changes by ±1 at every edge where stk_move=1 (+1 push, −1 pop). It never leaves 0..DEPTH.
- Stack contents below depth are never read.

## Timing
- Reset values: cmd_ready=1, stk_move=0, stk_mode=0, stk_in_word=0, depth=0, carry=0, err=0, err_ovf=0, err_unf=0; state IDLE.
- rst during any state aborts immediately. The stack is cleared by the same reset, so depth=0 stays consistent.
- Accept at edge E. The first step is driven during the cycle after E, and the stack commits at E+1.
- cmd_ready is low for the following number of cycles, then high again:
  - PUSH/POP/DUP: 1.
  - ADD/SUB: 3.
  - SWAP: 4.
  - CLR: depth at acceptance.
  - Error: 1.
- Result visibility on top_word (plus the next cycle's combinational settle):
  - PUSH/POP/DUP: after E+1.
  - ADD/SUB: after E+3.
  - SWAP: after E+4.
- Back-to-back throughput: one single-step command every 2 cycles.
- cmd_valid while busy is ignored; the requester must hold the command until ready.

## Test plan
- Reset, then PUSH 3, PUSH 5, ADD → top=8, depth=1, carry=0. cmd_ready low exactly 3 cycles for the ADD.
- PUSH 9, PUSH 0xA, ADD → top=3, carry=1. Then PUSH 4, SUB → top=0xF, carry=1 (borrow), depth=1.
- PUSH 1, PUSH 2, SWAP → top=1, second=2, depth=2. Exactly 4 stk_move cycles with modes 0,0,1,1 and in_words —,—,2,1.
- 8 PUSHes, then a 9th PUSH → err pulses 1 cycle, err_ovf=1, stk_move stays 0, depth=8. DUP at depth 8 behaves the same.
- POP at depth=0 and ADD at depth=1 → err_unf=1, depth unchanged. Then CLR clears both flags and pops to depth=0 in 1 cycle.
- Assert rst mid-SWAP (after SWP_POP2) → next cycle depth=0, cmd_ready=1, stk_move=0. A following PUSH 7 gives top=7, depth=1.
